// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the write side of an asynchronous FIFO
// among NUM_REQ requesters. Runs entirely in the FIFO write clock domain.
// A packet from one requester stays contiguous in the FIFO. The exception is
// when MAX_BURST is non-zero, the requester has written MAX_BURST words, and
// another requester is waiting: the grant then moves on.
//
// Ports:
//   clk        write-domain clock (FIFO clk_write)
//   rst        asynchronous, active-high reset
//   req        per-requester word valid (level)
//   req_data   packed word per requester, i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   final word of requester i's packet
//   ready      word from requester i accepted when req[i] && ready[i]
//   fifo_full  FIFO Full flag, already synchronized to the write domain
//   fifo_wr_en FIFO write enable
//   fifo_data  FIFO write data
//   owner      index of the current grant holder
//   busy       high while a grant is held
//
// state  | meaning
// IDLE   | no grant; arbitrate among req, next pick after last_owner
// GRANT  | owner drives the FIFO write port until release

module fifo_wr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_BURST   = 4,
   parameter int OWNER_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [OWNER_WIDTH-1:0]        owner,
   output logic                          busy
);

   localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                 state_q, state_d;
   logic [OWNER_WIDTH-1:0] owner_q, owner_d;
   logic [OWNER_WIDTH-1:0] last_owner_q, last_owner_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;

   logic [NUM_REQ-1:0]     own_oh;
   logic [NUM_REQ-1:0]     others;
   logic                   xfer;
   logic                   cap_hit;
   logic                   release_now;
   logic [OWNER_WIDTH:0]   pick_idle;
   logic [OWNER_WIDTH:0]   pick_rel;

   // First set bit of cand, searching from prev+1 upward with wrap.
   // The result is {found, index}.
   function automatic logic [OWNER_WIDTH:0] rr_pick(
      input logic [NUM_REQ-1:0]     cand,
      input logic [OWNER_WIDTH-1:0] prev
   );
      logic                   found;
      logic [OWNER_WIDTH-1:0] idx;
      logic [OWNER_WIDTH-1:0] p;
      found = 1'b0;
      idx   = '0;
      p     = prev;
      for (int k = 0; k < NUM_REQ; k++) begin
         p = (p == OWNER_WIDTH'(NUM_REQ-1)) ? '0 : p + 1'b1;
         if (!found && cand[p]) begin
            found = 1'b1;
            idx   = p;
         end
      end
      return {found, idx};
   endfunction

   assign own_oh  = NUM_REQ'(1) << owner_q;
   // On release, req[owner] still flags the word being consumed this cycle,
   // not a new request. The releasing owner is therefore left out of the
   // next pick. It can win again through IDLE a cycle later.
   assign others  = req & ~own_oh;
   assign busy    = (state_q == S_GRANT);
   assign xfer    = busy && req[owner_q] && !fifo_full;
   assign cap_hit = (MAX_BURST != 0) && (beat_q == BEAT_W'(MAX_BURST-1));

   assign pick_idle = rr_pick(req, last_owner_q);
   assign pick_rel  = rr_pick(others, owner_q);

   // In GRANT with fifo_full low, req[owner] high means a word transfers.
   // So (b) and (c) below only fire on a transfer cycle.
   assign release_now = !req[owner_q] || req_last[owner_q] || (cap_hit && |others);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_d       = beat_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = pick_idle[OWNER_WIDTH-1:0];
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!fifo_full) begin
               if (release_now) begin
                  last_owner_d = owner_q;
                  beat_d       = '0;
                  if (pick_rel[OWNER_WIDTH]) begin
                     owner_d = pick_rel[OWNER_WIDTH-1:0];
                  end else begin
                     state_d = S_IDLE;
                  end
               end else if (cap_hit) begin
                  beat_d = '0;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= '0;
         last_owner_q <= OWNER_WIDTH'(NUM_REQ-1);
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_q       <= beat_d;
      end
   end

   always_comb begin
      fifo_data = '0;
      if (busy) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OWNER_WIDTH'(i)) begin
               fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign ready      = (busy && !fifo_full) ? own_oh : '0;
   assign fifo_wr_en = xfer;
   assign owner      = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Each requester is driven from a packet
// queue. A scoreboard queue holds the expected {owner, data} order of FIFO
// writes, and a monitor compares every cycle that has fifo_wr_en high.

module tb_fifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req, req_last, ready;
   logic [NR*DW-1:0] req_data;
   logic          fifo_full, fifo_wr_en, busy;
   logic [DW-1:0] fifo_data;
   logic [1:0]    owner;

   logic [8:0]    pkt_q [NR][$];
   logic [9:0]    exp_q [$];
   logic [NR-1:0] en, acc;
   int            n_chk = 0, n_pass = 0, n_wr = 0;
   bit            wr;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ready(ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
      .fifo_data(fifo_data), .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   always @(negedge clk) begin : mon
      logic [9:0] e;
      #2;
      if (!rst && fifo_wr_en) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_extra: got %0h expected no write", {owner, fifo_data});
         end else begin
            e = exp_q.pop_front();
            chk("sb_word", 32'({owner, fifo_data}), 32'(e));
         end
      end
   end

   task automatic pk(input int r, input logic [7:0] d, input logic l);
      pkt_q[r].push_back({l, d});
   endtask

   task automatic ex(input logic [1:0] o, input logic [7:0] d);
      exp_q.push_back({o, d});
   endtask

   // One cycle: retire last cycle's handshakes, drive new words, sample.
   task automatic run_cycle(input bit full, output bit wr_o);
      logic [8:0] w;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         if (acc[i]) void'(pkt_q[i].pop_front());
         if (en[i] && pkt_q[i].size() > 0) begin
            w = pkt_q[i][0];
            req[i] = 1'b1;
            req_data[i*DW +: DW] = w[7:0];
            req_last[i] = w[8];
         end else begin
            req[i] = 1'b0;
            req_data[i*DW +: DW] = '0;
            req_last[i] = 1'b0;
         end
      end
      fifo_full = full;
      #1;
      acc  = req & ready;
      wr_o = fifo_wr_en;
   endtask

   task automatic flush();
      for (int i = 0; i < NR; i++) pkt_q[i].delete();
      exp_q.delete();
      en = '0; acc = '0; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      flush();
      #1;
      chk("rst_wr_en", 32'(fifo_wr_en), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_data", 32'(fifo_data), 0);

      // 1: single 3-word packet from requester 0
      do_reset();
      pk(0, 8'hA0, 0); pk(0, 8'hA1, 0); pk(0, 8'hA2, 1);
      ex(0, 8'hA0); ex(0, 8'hA1); ex(0, 8'hA2);
      en = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         run_cycle(0, wr);
         if (c == 0 || c == 4) begin
            chk("t1_busy_idle", 32'(busy), 0);
            chk("t1_wr_idle", 32'(wr), 0);
         end else begin
            chk("t1_wr", 32'(wr), 1);
            chk("t1_ready", 32'(ready), 1);
         end
      end
      chk("t1_left", 32'(exp_q.size()), 0);

      // 2: all requesters, single-word packets, rotate 0,1,2,3,0,...
      do_reset();
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < 2; k++) pk(r, 8'(16*r + k), 1);
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NR; r++) ex(2'(r), 8'(16*r + k));
      en = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         run_cycle(0, wr);
         if (c >= 1 && c <= 8) chk("t2_wr_cont", 32'(wr), 1);
      end
      chk("t2_left", 32'(exp_q.size()), 0);

      // 3: burst cap hands off to waiting requester 2, then back to 0
      do_reset();
      for (int k = 0; k < 8; k++) pk(0, 8'(8'h50 + k), k == 7);
      pk(2, 8'h60, 0); pk(2, 8'h61, 1);
      for (int k = 0; k < 4; k++) ex(0, 8'(8'h50 + k));
      ex(2, 8'h60); ex(2, 8'h61);
      for (int k = 4; k < 8; k++) ex(0, 8'(8'h50 + k));
      en = 4'b0101;
      n0 = n_wr;
      for (int c = 0; c < 13; c++) run_cycle(0, wr);
      chk("t3_count", 32'(n_wr - n0), 10);
      chk("t3_left", 32'(exp_q.size()), 0);

      // 4: fifo_full for 3 cycles after the 2nd word
      do_reset();
      for (int k = 0; k < 4; k++) begin
         pk(0, 8'(8'h70 + k), k == 3);
         ex(0, 8'(8'h70 + k));
      end
      en = 4'b0001;
      for (int c = 0; c < 9; c++) begin
         run_cycle(c >= 3 && c <= 5, wr);
         if (c >= 3 && c <= 5) begin
            chk("t4_full_wr", 32'(wr), 0);
            chk("t4_full_ready", 32'(ready), 0);
            chk("t4_full_owner", 32'(owner), 0);
            chk("t4_full_busy", 32'(busy), 1);
         end
         if (c == 6) chk("t4_resume", 32'(wr), 1);
      end
      chk("t4_left", 32'(exp_q.size()), 0);

      // 5: requester 0 abandons mid-packet while requester 1 waits
      do_reset();
      for (int k = 0; k < 4; k++) pk(0, 8'(8'h80 + k), k == 3);
      pk(1, 8'h90, 1);
      ex(0, 8'h80); ex(0, 8'h81); ex(1, 8'h90); ex(0, 8'h82); ex(0, 8'h83);
      en = 4'b0011;
      for (int c = 0; c < 3; c++) run_cycle(0, wr);
      en[0] = 1'b0;
      run_cycle(0, wr);
      @(posedge clk);
      #1;
      chk("t5_owner", 32'(owner), 1);
      chk("t5_busy", 32'(busy), 1);
      en[0] = 1'b1;
      for (int c = 4; c < 9; c++) run_cycle(0, wr);
      chk("t5_left", 32'(exp_q.size()), 0);

      // 6: asynchronous reset mid-burst, then req=0110 grants 1 first
      do_reset();
      for (int k = 0; k < 4; k++) pk(0, 8'(8'hB0 + k), k == 3);
      ex(0, 8'hB0); ex(0, 8'hB1);
      en = 4'b0001;
      for (int c = 0; c < 3; c++) run_cycle(0, wr);
      chk("t6_pre_wr", 32'(wr), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_wr", 32'(fifo_wr_en), 0);
      chk("t6_async_ready", 32'(ready), 0);
      chk("t6_async_busy", 32'(busy), 0);
      chk("t6_pre_left", 32'(exp_q.size()), 0);
      flush();
      #3;
      rst = 1'b0;
      pk(1, 8'hC1, 1); pk(2, 8'hC2, 1);
      ex(1, 8'hC1); ex(2, 8'hC2);
      en = 4'b0110;
      run_cycle(0, wr);
      @(posedge clk);
      #1;
      chk("t6_first_owner", 32'(owner), 1);
      for (int c = 1; c < 5; c++) run_cycle(0, wr);
      chk("t6_left", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of the asynchronous FIFO among NUM_REQ requesters. It sits entirely in the FIFO write clock domain. It drives the FIFO write enable and write data, and observes the FIFO Full flag. Packets from one requester stay contiguous in the FIFO unless the burst cap forces a handoff to a waiting requester.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, FIFO word width; must match the FIFO DATA_WIDTH
MAX_BURST, 4, maximum words per grant while another requester waits; 0 = unlimited (packets atomic)
OWNER_WIDTH, $clog2(NUM_REQ), width of the owner index

Ports:
clk  in  1  write-domain clock (same clock as FIFO clk_write)
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester word-valid, level
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  in  NUM_REQ  marks the final word of requester i's packet
ready  out  NUM_REQ  word accepted from requester i when req[i] && ready[i]
fifo_full  in  1  FIFO Full flag (write-domain synchronized)
fifo_wr_en  out  1  FIFO write enable
fifo_data  out  DATA_WIDTH  FIFO write data
owner  out  OWNER_WIDTH  index of the current grant holder
busy  out  1  high while in GRANT

Behaviour:
- One clock (clk), asynchronous active-high reset (rst). All state is cleared immediately on rst, independent of clk.
- Reset values:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1 (so requester 0 wins first), beat_cnt=0.
  - Outputs: fifo_wr_en=0, ready=0, fifo_data=0, busy=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req bit is set, the round-robin pick is made starting at last_owner+1 and wrapping modulo NUM_REQ.
  - The winner is registered into owner; state goes to GRANT on the next edge (1-cycle arbitration latency).
  - No req: stay in IDLE.
- GRANT, outputs (combinational from registered state):
  - ready[owner] = !fifo_full; all other ready bits = 0.
  - fifo_wr_en = req[owner] && !fifo_full.
  - fifo_data = req_data[owner] while in GRANT; 0 in IDLE.
- Transfer: a word transfers on any cycle with fifo_wr_en=1 (zero added latency); beat_cnt increments on each transfer.
- Release conditions in GRANT (evaluated each cycle), in priority order:
  a) req[owner]=0 (abandon).
  b) A transfer with req_last[owner]=1.
  c) A transfer with beat_cnt==MAX_BURST-1, MAX_BURST!=0, and at least one other req bit set.
  If (c) applies but no other requester waits, beat_cnt resets to 0 and owner keeps the grant.
- On release:
  - last_owner<=owner and beat_cnt<=0.
  - Round-robin pick is made over req, masked so the releasing owner has lowest priority; on abandon, the releasing owner's req is excluded.
  - Winner found: stay in GRANT with the new owner next cycle (back-to-back, no idle bubble).
  - No winner: go to IDLE.
- fifo_full=1: no transfer, state/owner/beat_cnt frozen, grant retained. Writes never issue while full, so no word is dropped by the FIFO's internal full gating.
- A requester must hold req_data and req_last stable while req=1 and the word has not yet been accepted.
- Simultaneous req_last and burst cap on the same transfer: treated as release (b).
- owner wraps NUM_REQ-1 -> 0. beat_cnt is sized to hold MAX_BURST-1.

Test Plan:
1. NUM_REQ=4, MAX_BURST=4: req[0]=1 with a 3-word packet (A0,A1,A2; last on A2), fifo_full=0 -> cycle 0 IDLE; cycles 1-3 ready[0]=1, fifo_wr_en=1, fifo_data=A0,A1,A2; cycle 4 busy=0.
2. req[3:0]=1111, every word has req_last=1 -> owners 0,1,2,3,0 on consecutive cycles; fifo_wr_en continuous from cycle 1.
3. req[0] sends an 8-word packet, req[2] pending from cycle 0 -> words 0-3 from requester 0, then requester 2's 2-word packet, then words 4-7 from requester 0. FIFO holds exactly 10 words, no duplicates.
4. fifo_full=1 for 3 cycles after the 2nd word of a 4-word packet -> fifo_wr_en=0, ready=0, owner unchanged; resumes with word 3; FIFO content is in order.
5. Owner drops req mid-packet while req[1] waits -> owner=1 on the next cycle; the abandoning requester gets lowest priority.
6. Assert rst asynchronously mid-burst -> fifo_wr_en, ready and busy drop to 0 without a clk edge. After rst=0 with req=0110, requester 1 is granted first.
